part3_mac_collector: RTL and testbench
======================================

PART3_MAC_COLLECTOR -- requirements
Module: part3_mac_collector

Interface
REQ-001 SHALL have parameter VEC_LEN, default 4: number of MAC results per dot product (legal range 1..255).
REQ-002 SHALL have parameter DEPTH, default 4: result FIFO entries (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port f, input, signed 16 bits: MAC accumulator value.
REQ-006 SHALL have port valid_in, input, 1 bit: connects to MAC valid_out; f is valid this cycle.
REQ-007 SHALL have port mac_clr, output, 1 bit: drives the MAC reset to clear its accumulator.
REQ-008 SHALL have port out_data, output, signed 16 bits: FIFO head, i.e. the completed dot product.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag; a result was dropped.
REQ-012 SHALL have port level, output, $clog2(DEPTH)+1 bits: FIFO occupancy.

Function
REQ-013 SHALL implement an FSM with states ACCUM, CLR1 and CLR2; reset state is ACCUM.
REQ-014 In ACCUM, each valid_in cycle SHALL increment beat counter cnt (8 bits, reset 0).
REQ-015 In ACCUM, valid_in with cnt==VEC_LEN-1 is a "capture": cnt<=0, FSM->CLR1, push f into the FIFO.
REQ-016 SHALL assert mac_clr registered, high exactly during CLR1 and CLR2 (2 cycles); CLR1->CLR2->ACCUM unconditionally.
REQ-017 valid_in during CLR1/CLR2 SHALL be ignored: no count, no push.
REQ-018 Pop SHALL occur when out_valid && out_ready; out_valid = (level != 0).
REQ-019 Push SHALL succeed when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
REQ-020 A capture with a full FIFO and no pop SHALL drop f, set overflow (sticky until reset), and still enter CLR1.
REQ-021 Simultaneous push and pop SHALL leave level unchanged and keep FIFO order.
REQ-022 There SHALL be no bypass: a result pushed into an empty FIFO gives out_valid on the next cycle.
REQ-023 out_data SHALL hold stable while out_valid && !out_ready.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH.
REQ-025 f SHALL be stored bit-exact, with no saturation or truncation.
REQ-026 With VEC_LEN==1, every ACCUM valid_in SHALL be a capture.

Reset
REQ-027 While reset is high, outputs SHALL be: mac_clr=0, out_valid=0, out_data=0, overflow=0, level=0; FSM=ACCUM, cnt=0, pointers=0.
REQ-028 Reset asserted mid-dot-product or mid-CLR SHALL discard the partial count and all FIFO contents immediately, without waiting for a clock edge.
REQ-029 The first capture after reset deassertion SHALL require a full VEC_LEN valid_in beats.

Verification
REQ-030 Scenario: VEC_LEN=4, valid_in on 4 consecutive cycles with f=3,8,15,24, out_ready=1 -> 24 pushed; mac_clr high for the next 2 cycles; out_valid=1 with out_data=24 one cycle after capture; level returns to 0.
REQ-031 Scenario: out_ready=0, 5 captures with DEPTH=4 and values 10,20,30,40,50 -> level=4, overflow=1, 50 dropped; then out_ready=1 -> outputs 10,20,30,40 in order.
REQ-032 Scenario: FIFO full, capture in the same cycle as a pop -> push accepted, level stays 4, overflow stays 0.
REQ-033 Scenario: valid_in held high through CLR1/CLR2 -> those beats are not counted; the next capture occurs at the 4th beat after returning to ACCUM.
REQ-034 Scenario: reset pulse after 2 of 4 beats, with 1 entry queued -> level=0, out_valid=0; a capture then needs 4 new beats.
REQ-035 Scenario: f=-32768 (0x8000) captured -> out_data=0x8000 exactly.

Source files
------------

// File: rtl/part3_mac_collector.sv
// Collects every VEC_LEN-th MAC accumulator value into a result FIFO.
// After each capture it pulses mac_clr for two cycles to clear the MAC.
module part3_mac_collector #(
  parameter int VEC_LEN = 4,
  parameter int DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [15:0]      f,
  input  logic                    valid_in,
  output logic                    mac_clr,
  output logic signed [15:0]      out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0] LAST = 8'(VEC_LEN - 1);

  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] CLR1  = 2'd1;
  localparam logic [1:0] CLR2  = 2'd2;

  logic [1:0]         r_state;
  logic [7:0]         r_cnt;
  logic               r_mac_clr;
  logic               r_overflow;
  logic signed [15:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr;
  logic [AW-1:0]      r_rd;
  logic [LW-1:0]      r_level;

  logic w_beat;
  logic w_capture;
  logic w_pop;
  logic w_push;

  assign w_beat    = (r_state == ACCUM) && valid_in;
  assign w_capture = w_beat && (r_cnt == LAST);
  assign w_pop     = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves this cycle
  assign w_push    = w_capture &&
                     ((r_level < LW'(DEPTH)) || w_pop);

  assign out_valid = (r_level != '0);
  assign out_data  = out_valid ? r_mem[r_rd] : '0;
  assign mac_clr   = r_mac_clr;
  assign overflow  = r_overflow;
  assign level     = r_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ACCUM;
      r_cnt     <= '0;
      r_mac_clr <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_capture) begin
            r_cnt     <= '0;
            r_state   <= CLR1;
            r_mac_clr <= 1'b1;
          end else if (w_beat) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        CLR1: begin
          r_state   <= CLR2;
          r_mac_clr <= 1'b1;
        end
        CLR2: begin
          r_state   <= ACCUM;
          r_mac_clr <= 1'b0;
        end
        default: begin
          r_state   <= ACCUM;
          r_mac_clr <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_capture && !w_push) r_overflow <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= f;
  end

endmodule

// File: tb/tb_part3_mac_collector.sv
// Directed bench for part3_mac_collector with a result scoreboard.
module tb_part3_mac_collector;

  logic               clk;
  logic               reset;
  logic signed [15:0] f;
  logic               valid_in;
  logic               mac_clr;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               overflow;
  logic [2:0]         level;

  int errors = 0;
  int checks = 0;
  logic signed [15:0] q[$];

  part3_mac_collector #(.VEC_LEN(4), .DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .f(f),
    .valid_in(valid_in),
    .mac_clr(mac_clr),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow(overflow),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic signed [15:0] v);
    valid_in = 1'b1;
    f = v;
    step();
    valid_in = 1'b0;
  endtask

  task automatic capture(input logic signed [15:0] v);
    beat(16'sd1);
    beat(16'sd2);
    beat(16'sd3);
    beat(v);
    step();
    step();
  endtask

  // A pop happens at the next rising edge; compare the head now
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      logic signed [15:0] e;
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL pop_unexpected: got %0h expected none",
               out_data);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        assert (out_data === e) else begin
          errors++;
          $error("FAIL pop_data: got %0h expected %0h",
                 out_data, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    f = '0;
    valid_in = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_mac_clr", mac_clr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_level", level, 0);
    step();
    step();
    reset = 1'b0;
    step();

    // basic dot product
    out_ready = 1'b1;
    beat(16'sd3);
    beat(16'sd8);
    beat(16'sd15);
    q.push_back(16'sd24);
    beat(16'sd24);
    chk("s1_mac_clr1", mac_clr, 1);
    chk("s1_out_valid", out_valid, 1);
    chk("s1_out_data", out_data, 24);
    chk("s1_level1", level, 1);
    step();
    chk("s1_mac_clr2", mac_clr, 1);
    chk("s1_level0", level, 0);
    step();
    chk("s1_mac_clr_off", mac_clr, 0);

    // fill and overflow
    out_ready = 1'b0;
    for (int v = 10; v <= 40; v += 10) begin
      q.push_back(16'(v));
      capture(16'(v));
    end
    capture(16'sd50);
    chk("s2_level", level, 4);
    chk("s2_overflow", overflow, 1);
    chk("s2_out_valid", out_valid, 1);
    chk("s2_hold", out_data, 10);
    out_ready = 1'b1;
    repeat (5) step();
    chk("s2_drained", level, 0);
    chk("s2_sticky", overflow, 1);
    out_ready = 1'b0;

    // async reset mid dot product with one entry queued
    q.push_back(16'sd77);
    capture(16'sd77);
    beat(16'sd1);
    beat(16'sd2);
    chk("s4_pre_level", level, 1);
    reset = 1'b1;
    #2;
    chk("s4_level", level, 0);
    chk("s4_out_valid", out_valid, 0);
    chk("s4_out_data", out_data, 0);
    chk("s4_overflow", overflow, 0);
    chk("s4_mac_clr", mac_clr, 0);
    q.delete();
    #1;
    reset = 1'b0;
    beat(16'sd5);
    beat(16'sd6);
    beat(16'sd7);
    chk("s4_no_cap_level", level, 0);
    chk("s4_no_cap_clr", mac_clr, 0);
    q.push_back(16'sd88);
    beat(16'sd88);
    chk("s4_cap_level", level, 1);
    chk("s4_cap_clr", mac_clr, 1);
    out_ready = 1'b1;
    step();
    step();
    chk("s4_drained", level, 0);

    // capture into a full FIFO while popping
    out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      q.push_back(16'(v));
      capture(16'(v));
    end
    chk("s3_full", level, 4);
    beat(16'sd1);
    beat(16'sd2);
    beat(16'sd3);
    out_ready = 1'b1;
    q.push_back(16'sd5);
    beat(16'sd5);
    out_ready = 1'b0;
    chk("s3_level", level, 4);
    chk("s3_overflow", overflow, 0);
    out_ready = 1'b1;
    repeat (6) step();
    chk("s3_drained", level, 0);

    // valid_in held high through the clear cycles
    for (int i = 0; i < 10; i++) begin
      valid_in = 1'b1;
      if (i == 3) f = 16'sd100;
      else if (i == 9) f = 16'sd200;
      else f = 16'(1000 + i);
      if (i == 3 || i == 9) q.push_back(f);
      step();
      if (i == 3) chk("s5_cap1_clr", mac_clr, 1);
      if (i == 8) begin
        chk("s5_idle_clr", mac_clr, 0);
        chk("s5_idle_level", level, 0);
      end
      if (i == 9) begin
        chk("s5_cap2_clr", mac_clr, 1);
        chk("s5_cap2_level", level, 1);
      end
    end
    valid_in = 1'b0;
    step();
    step();

    // most negative value stored exactly
    q.push_back(16'sh8000);
    capture(16'sh8000);
    step();
    chk("s6_queue_empty", 32'(q.size()), 0);
    chk("s6_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
